// File: rtl/offnariscv_pkg.sv
// Shared ACE read-channel types and read-arbiter constants for the offnariscv core.
// The read arbiter's priority mode is selected by OFFNARISCV_RD_ARB_LSU_PRIO_EN (see offnariscv_rr_arb2).
package offnariscv_pkg;

   localparam int ACE_XDATA_WIDTH  = 256;
   localparam int ACE_AXADDR_WIDTH = 32;
   localparam int ACE_ID_WIDTH     = 4;
   localparam int ACE_USER_WIDTH   = 1;

   typedef struct packed {
      logic [ACE_ID_WIDTH-1:0]     id;
      logic [ACE_AXADDR_WIDTH-1:0] addr;
      logic [7:0]                  len;
      logic [2:0]                  size;
      logic [1:0]                  burst;
      logic                        lock;
      logic [3:0]                  cache;
      logic [2:0]                  prot;
      logic [3:0]                  qos;
      logic [3:0]                  region;
      logic [ACE_USER_WIDTH-1:0]   user;
      logic [3:0]                  snoop;
      logic [1:0]                  domain;
      logic [1:0]                  bar;
   } ace_ar_t;

   typedef struct packed {
      logic [ACE_ID_WIDTH-1:0]    id;
      logic [ACE_XDATA_WIDTH-1:0] data;
      logic [3:0]                 resp;
      logic                       last;
      logic [ACE_USER_WIDTH-1:0]  user;
   } ace_r_t;

   typedef enum logic [1:0] {IDLE, AR, R, ACK} rd_arb_state_e;

   localparam logic RD_ARB_IFU = 1'b0;
   localparam logic RD_ARB_LSU = 1'b1;

endpackage

// File: rtl/offnariscv_rr_arb2.sv
// Two-way combinational pick producing a one-hot grant; round-robin on ties,
// or fixed LSU priority when OFFNARISCV_RD_ARB_LSU_PRIO_EN is defined.
module offnariscv_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);

`ifdef OFFNARISCV_RD_ARB_LSU_PRIO_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   always_comb begin
      grant = 2'b00;
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
   end
`else
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         // Tie goes to whoever was not served last.
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end
`endif

endmodule

// File: rtl/offnariscv_ace_rd_arbiter.sv
// Shares one downstream ACE read port between IFU (0) and LSU (1), one transaction at a time.
// Tie-break mode follows OFFNARISCV_RD_ARB_LSU_PRIO_EN (fixed LSU priority when defined).
module offnariscv_ace_rd_arbiter
   import offnariscv_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  ace_ar_t [1:0]      s_ar,
   input  logic    [1:0]      s_arvalid,
   output logic    [1:0]      s_arready,
   output ace_r_t  [1:0]      s_r,
   output logic    [1:0]      s_rvalid,
   input  logic    [1:0]      s_rready,
   input  logic    [1:0]      s_rack,
   output ace_ar_t            m_ar,
   output logic               m_arvalid,
   input  logic               m_arready,
   input  ace_r_t             m_r,
   input  logic               m_rvalid,
   output logic               m_rready,
   output logic               m_rack
);

   rd_arb_state_e state;
   logic          owner;
   logic          last_grant;
   logic [1:0]    grant;

   offnariscv_rr_arb2 u_arb (
      .req        (s_arvalid),
      .last_grant (last_grant),
      .grant      (grant)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= RD_ARB_IFU;
         last_grant <= RD_ARB_LSU;
      end else begin
         case (state)
            IDLE: if (|s_arvalid) begin
               owner <= grant[1];
               state <= AR;
            end
            AR:  if (m_arvalid && m_arready) state <= R;
            R:   if (m_rvalid && m_rready && m_r.last) state <= ACK;
            ACK: if (s_rack[owner]) begin
               last_grant <= owner;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode from registered state/owner only, so no ready feeds back into a valid.
   always_comb begin
      s_arready = 2'b00;
      s_rvalid  = 2'b00;
      s_r[0]    = m_r;
      s_r[1]    = m_r;
      m_ar      = '0;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      m_rack    = 1'b0;
      case (state)
         AR: begin
            m_ar             = s_ar[owner];
            m_arvalid        = s_arvalid[owner];
            s_arready[owner] = m_arready;
         end
         R: begin
            s_rvalid[owner] = m_rvalid;
            m_rready        = s_rready[owner];
         end
         ACK:     m_rack = s_rack[owner];
         default: ;
      endcase
   end

endmodule

// File: tb/tb_offnariscv_ace_rd_arbiter.sv
// Scoreboard bench for offnariscv_ace_rd_arbiter: drivers push expected AR/R records, a negedge monitor pops them.
module tb_offnariscv_ace_rd_arbiter;
   import offnariscv_pkg::*;

   localparam int AR_W     = 34;
   localparam int R_W      = 67;
   localparam int WAIT_MAX = 50;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   ace_ar_t [1:0] s_ar;
   logic    [1:0] s_arvalid;
   logic    [1:0] s_arready;
   ace_r_t  [1:0] s_r;
   logic    [1:0] s_rvalid;
   logic    [1:0] s_rready;
   logic    [1:0] s_rack;
   ace_ar_t       m_ar;
   logic          m_arvalid;
   logic          m_arready;
   ace_r_t        m_r;
   logic          m_rvalid;
   logic          m_rready;
   logic          m_rack;

   logic [AR_W-1:0] exp_ar_q[$];
   logic [R_W-1:0]  exp_r_q[$];
   int n_chk  = 0;
   int n_fail = 0;

   offnariscv_ace_rd_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .s_ar      (s_ar),
      .s_arvalid (s_arvalid),
      .s_arready (s_arready),
      .s_r       (s_r),
      .s_rvalid  (s_rvalid),
      .s_rready  (s_rready),
      .s_rack    (s_rack),
      .m_ar      (m_ar),
      .m_arvalid (m_arvalid),
      .m_arready (m_arready),
      .m_r       (m_r),
      .m_rvalid  (m_rvalid),
      .m_rready  (m_rready),
      .m_rack    (m_rack)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input int who, input logic [31:0] addr, input logic [7:0] len);
      s_ar[who]       = '0;
      s_ar[who].id    = 4'(who + 1);
      s_ar[who].addr  = addr;
      s_ar[who].len   = len;
      s_ar[who].size  = 3'd5;
      s_ar[who].burst = 2'b01;
      s_arvalid[who]  = 1'b1;
   endtask

   task automatic wait_ar(input int who, output int cycles);
      cycles = 0;
      while (1) begin
         @(negedge clk);
         chk("ar_other_ready", s_arready[1-who], 0);
         if (m_arvalid && m_arready) break;
         cycles++;
         if (cycles >= WAIT_MAX) begin
            chk("ar_timeout", 1, 0);
            break;
         end
      end
      step();
      s_arvalid[who] = 1'b0;
      m_arready      = 1'b0;
   endtask

   // Plays the downstream slave and requester `who` for one full transaction.
   task automatic serve(input int who, input logic [31:0] addr, input int len, input int ar_stall,
                        input bit gaps, input bit toggle, output int ar_cycles);
      int n;
      logic [1:0] oh;
      logic [31:0] d;
      oh = (who == 1) ? 2'b10 : 2'b01;
      exp_ar_q.push_back({oh, addr});
      if (ar_stall > 0) begin
         m_arready = 1'b0;
         step();
         for (int i = 0; i < ar_stall; i++) begin
            @(negedge clk);
            chk("ar_stall_valid", m_arvalid, 1);
            chk("ar_stall_addr", m_ar.addr, addr);
            chk("ar_stall_ready", s_arready, 0);
            step();
         end
      end
      m_arready = 1'b1;
      wait_ar(who, ar_cycles);
      for (int b = 0; b <= len; b++) begin
         if (gaps) begin
            m_rvalid       = 1'b0;
            s_rready[who]  = 1'b1;
            for (int g = 0; g < (b % 2) + 1; g++) begin
               @(negedge clk);
               chk("gap_in_r_rready", m_rready, 1);
               chk("gap_no_rvalid", s_rvalid, 0);
               step();
            end
         end
         d          = addr + 32'(b);
         m_r        = '0;
         m_r.id     = 4'(who + 1);
         m_r.data   = {224'h0, d};
         m_r.last   = (b == len);
         m_rvalid   = 1'b1;
         s_rready[who] = !toggle;
         exp_r_q.push_back({oh, d, d, (b == len)});
         n = 0;
         while (1) begin
            @(negedge clk);
            chk("r_other_arready", s_arready[1-who], 0);
            if (m_rvalid && m_rready) break;
            chk("bp_rvalid_held", s_rvalid, oh);
            n++;
            if (n >= WAIT_MAX) begin
               chk("r_timeout", 1, 0);
               break;
            end
            step();
            s_rready[who] = 1'b1;
         end
         step();
      end
      // Stray beat in ACK must be stalled; the other requester's RACK is ignored.
      m_r.last        = 1'b0;
      m_rvalid        = 1'b1;
      s_rready[who]   = 1'b1;
      s_rack[1-who]   = 1'b1;
      @(negedge clk);
      chk("ack_stall_rready", m_rready, 0);
      chk("ack_no_fwd", s_rvalid, 0);
      chk("ack_other_rack", m_rack, 0);
      step();
      m_rvalid      = 1'b0;
      s_rready[who] = 1'b0;
      s_rack[1-who] = 1'b0;
      s_rack[who]   = 1'b1;
      @(negedge clk);
      chk("rack_fwd", m_rack, 1);
      step();
      s_rack[who] = 1'b0;
      @(negedge clk);
      chk("idle_after_rack", {m_arvalid, m_rack, m_rready}, 0);
      chk("idle_arready", s_arready, 0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (m_arvalid && m_arready) begin
            if (exp_ar_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL ar_unexpected: got addr %0h, none expected", m_ar.addr);
            end else begin
               chk("ar_handshake", {s_arready, m_ar.addr}, exp_ar_q.pop_front());
            end
         end
         if (m_rvalid && m_rready) begin
            if (exp_r_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL r_unexpected: got data %0h, none expected", m_r.data[31:0]);
            end else begin
               chk("r_beat", {s_rvalid, s_r[1].data[31:0], s_r[0].data[31:0], s_r[0].last},
                   exp_r_q.pop_front());
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      s_ar      = '0;
      s_arvalid = 2'b00;
      s_rready  = 2'b00;
      s_rack    = 2'b00;
      m_arready = 1'b0;
      m_r       = '0;
      m_rvalid  = 1'b0;

      // Reset: outputs quiet even with every input asserted.
      s_arvalid = 2'b11;
      s_rready  = 2'b11;
      s_rack    = 2'b11;
      m_rvalid  = 1'b1;
      m_arready = 1'b1;
      step();
      @(negedge clk);
      chk("reset_outputs", {m_arvalid, m_rready, m_rack, s_arready, s_rvalid}, 0);
      chk("reset_m_ar", m_ar, 0);
      s_arvalid = 2'b00;
      s_rready  = 2'b00;
      s_rack    = 2'b00;
      m_rvalid  = 1'b0;
      m_arready = 1'b0;
      step();
      rst = 1'b0;
      step();

      // Tie straight after reset.
      req(0, 32'h2000, 8'd0);
      req(1, 32'h3000, 8'd1);
`ifdef OFFNARISCV_RD_ARB_LSU_PRIO_EN
      serve(1, 32'h3000, 1, 0, 1'b0, 1'b0, cyc);
      serve(0, 32'h2000, 0, 0, 1'b0, 1'b0, cyc);
`else
      serve(0, 32'h2000, 0, 0, 1'b0, 1'b0, cyc);
      serve(1, 32'h3000, 1, 0, 1'b0, 1'b0, cyc);
`endif

      // IFU alone: m_arvalid only from the cycle after the request.
      step();
      req(0, 32'h1000, 8'd0);
      @(negedge clk);
      chk("t1_no_early_arvalid", m_arvalid, 0);
      serve(0, 32'h1000, 0, 0, 1'b0, 1'b0, cyc);
      chk("t1_ar_latency", cyc, 0);

      // Tie after IFU was last served: LSU first in either mode.
      step();
      req(0, 32'h2100, 8'd0);
      req(1, 32'h3100, 8'd0);
      serve(1, 32'h3100, 0, 0, 1'b0, 1'b0, cyc);
      serve(0, 32'h2100, 0, 0, 1'b0, 1'b0, cyc);

      // LSU 4-beat burst with gaps and rready backpressure.
      step();
      req(1, 32'h4000, 8'd3);
      serve(1, 32'h4000, 3, 0, 1'b1, 1'b1, cyc);

      // Downstream AR stall for 5 cycles.
      step();
      req(0, 32'h5000, 8'd0);
      serve(0, 32'h5000, 0, 5, 1'b0, 1'b0, cyc);

      // LSU arrives while IFU owns the port.
      step();
      req(0, 32'h5800, 8'd1);
      step();
      req(1, 32'h5900, 8'd0);
      serve(0, 32'h5800, 1, 0, 1'b1, 1'b0, cyc);
      serve(1, 32'h5900, 0, 0, 1'b0, 1'b0, cyc);

      // Reset in the middle of an R burst.
      step();
      req(0, 32'h6000, 8'd3);
      m_arready = 1'b1;
      exp_ar_q.push_back({2'b01, 32'h6000});
      wait_ar(0, cyc);
      m_r       = '0;
      m_r.data  = {224'h0, 32'h6000};
      m_rvalid  = 1'b1;
      s_rready  = 2'b01;
      exp_r_q.push_back({2'b01, 32'h6000, 32'h6000, 1'b0});
      @(negedge clk);
      step();
      m_r.data  = {224'h0, 32'h6001};
      chk("pre_rst_rvalid", s_rvalid, 2'b01);
      s_arvalid[1] = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async_outputs", {m_arvalid, m_rready, m_rack, s_arready, s_rvalid}, 0);
      chk("rst_async_m_ar", m_ar, 0);
      step();
      m_rvalid  = 1'b0;
      s_rready  = 2'b00;
      s_arvalid = 2'b00;
      step();
      rst = 1'b0;
      step();
      req(0, 32'h7000, 8'd0);
      serve(0, 32'h7000, 0, 0, 1'b0, 1'b0, cyc);

      step();
      chk("ar_queue_drained", exp_ar_q.size(), 0);
      chk("r_queue_drained", exp_r_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
